// File: rtl/sb_param_pkg.sv
// Shared types and sizing helpers for the parametrised switch-block tile.
// Optional SB_CFG_PARITY_EN (see sb_param_cfg_tile) does not change anything here.
package sb_param_pkg;

  localparam int NUM_SIDES = 4;

  typedef enum logic [1:0] {
    RIGHT  = 2'd0,
    TOP    = 2'd1,
    BOTTOM = 2'd2,
    LEFT   = 2'd3
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERR   = 2'd3
  } cfg_state_e;

  // One extra code beyond the inputs so sel=0 can mean "drive 0".
  function automatic int sel_w(input int n_in);
    return $clog2(n_in + 1);
  endfunction

  function automatic int cfg_bits(input int chan_w, input int sel_width);
    return NUM_SIDES * chan_w * sel_width;
  endfunction

endpackage

// File: rtl/sb_param_track_mux.sv
// Single output-track mux: sel=k (1..N_IN) drives in_i[k-1]; sel=0 or above N_IN drives 0.
// Purely combinational.
module sb_param_track_mux #(
  parameter int N_IN  = 19,
  parameter int SEL_W = 5
) (
  input  logic [N_IN-1:0]  in_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             out_o
);

  always_comb begin
    out_o = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_W'(i + 1)) out_o = in_i[i];
    end
  end

endmodule

// File: rtl/sb_param_cfg_tile.sv
// 4-sided switch block with a shadow config chain committed to the active routing by handshake.
// Define SB_CFG_PARITY_EN to append an even-parity bit to the chain and check it on commit.
module sb_param_cfg_tile
  import sb_param_pkg::*;
#(
  parameter int CHAN_W  = 5,
  parameter int NUM_PIN = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_head,
  input  logic              cfg_en,
  input  logic              cfg_commit,
  input  logic              cfg_abort,
  output logic              ccff_tail,
  output logic              cfg_ack,
  output logic              cfg_err,
  input  logic [CHAN_W-1:0] chanx_right_in,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [NUM_PIN-1:0] pin_right_in,
  input  logic [NUM_PIN-1:0] pin_top_in,
  input  logic [NUM_PIN-1:0] pin_bottom_in,
  input  logic [NUM_PIN-1:0] pin_left_in,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic [CHAN_W-1:0] chanx_left_out
);

  localparam int N_IN     = NUM_PIN + 3 * CHAN_W;
  localparam int SEL_W    = sel_w(N_IN);
  localparam int CFG_BITS = cfg_bits(CHAN_W, SEL_W);
`ifdef SB_CFG_PARITY_EN
  localparam int PAR_W    = 1;
`else
  localparam int PAR_W    = 0;
`endif
  localparam int CHAIN_LEN = CFG_BITS + PAR_W;
  localparam int CNT_W     = $clog2(CFG_BITS + 2);

  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0]  active_q;
  logic [CNT_W-1:0]     cnt_q;
  cfg_state_e           state_q;
  logic                 tail_q, ack_q, err_q;

  logic full_commit, parity_ok, shift_en;

  assign full_commit = (state_q == ST_FULL) && cfg_commit;
`ifdef SB_CFG_PARITY_EN
  assign parity_ok   = ~^shadow_q;
`else
  assign parity_ok   = 1'b1;
`endif
  // A commit landing on a full chain consumes the cycle: the simultaneous shift is dropped.
  assign shift_en    = cfg_en && !cfg_abort && !full_commit;
  assign shadow_d    = shift_en ? {shadow_q[CHAIN_LEN-2:0], ccff_head} : shadow_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      tail_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      shadow_q <= shadow_d;
      if (shift_en) tail_q <= shadow_q[CHAIN_LEN-1];
      if (cfg_abort) begin
        cnt_q   <= '0;
        state_q <= ST_IDLE;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cfg_commit) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (cfg_en) begin
              cnt_q   <= CNT_W'(1);
              state_q <= (CHAIN_LEN == 1) ? ST_FULL : ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (cfg_commit) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (cfg_en) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(CHAIN_LEN - 1)) state_q <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (cfg_commit) begin
              if (parity_ok) begin
                active_q <= shadow_q[CFG_BITS-1:0];
                ack_q    <= 1'b1;
                cnt_q    <= '0;
                state_q  <= ST_IDLE;
              end else begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end else if (cfg_en) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
          default: begin
            // Error is sticky until abort; shifts pass through uncounted.
            err_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ccff_tail = tail_q;
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;

  logic [NUM_SIDES-1:0][CHAN_W-1:0]  chan_in;
  logic [NUM_SIDES-1:0][NUM_PIN-1:0] pin_in;
  logic [NUM_SIDES-1:0][CHAN_W-1:0]  chan_out;

  assign chan_in[RIGHT]  = chanx_right_in;
  assign chan_in[TOP]    = chany_top_in;
  assign chan_in[BOTTOM] = chany_bottom_in;
  assign chan_in[LEFT]   = chanx_left_in;
  assign pin_in[RIGHT]   = pin_right_in;
  assign pin_in[TOP]     = pin_top_in;
  assign pin_in[BOTTOM]  = pin_bottom_in;
  assign pin_in[LEFT]    = pin_left_in;

  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    logic [N_IN-1:0] mux_in;
    assign mux_in[NUM_PIN-1:0] = pin_in[s];
    // The three other sides in fixed order; the own side is skipped so no U-turn exists.
    for (genvar j = 0; j < 3; j++) begin : g_src
      localparam int O = (j < s) ? j : j + 1;
      assign mux_in[NUM_PIN + j*CHAN_W +: CHAN_W] = chan_in[O];
    end
    for (genvar t = 0; t < CHAN_W; t++) begin : g_trk
      localparam int K = s * CHAN_W + t;
      sb_param_track_mux #(
        .N_IN (N_IN),
        .SEL_W(SEL_W)
      ) u_mux (
        .in_i (mux_in),
        .sel_i(active_q[K*SEL_W +: SEL_W]),
        .out_o(chan_out[s][t])
      );
    end
  end

  assign chanx_right_out  = chan_out[RIGHT];
  assign chany_top_out    = chan_out[TOP];
  assign chany_bottom_out = chan_out[BOTTOM];
  assign chanx_left_out   = chan_out[LEFT];

endmodule

// File: tb/tb_sb_param_cfg_tile.sv
// Bench for sb_param_cfg_tile: decode table, randomized configs vs. a field-level model, handshake corners.
module tb_sb_param_cfg_tile;

  localparam int CHAN_W = 5, NUM_PIN = 4, N_IN = 19, SEL_W = 5, CFG_BITS = 100, NOUT = 20;
`ifdef SB_CFG_PARITY_EN
  localparam int L = CFG_BITS + 1;
`else
  localparam int L = CFG_BITS;
`endif
  localparam int K_PIN = 0, K_CHAN = 1, K_ALL = 2, K_SELF = 3;

  logic prog_clk = 1'b0;
  logic pReset, ccff_head, cfg_en, cfg_commit, cfg_abort;
  wire  ccff_tail, cfg_ack, cfg_err;
  logic [CHAN_W-1:0]  chan_v [4];
  logic [NUM_PIN-1:0] pin_v  [4];
  wire  [CHAN_W-1:0]  co_r, co_t, co_b, co_l;
  wire  [NOUT-1:0]    outs = {co_l, co_b, co_t, co_r};

  int   total = 0, bad = 0;
  int   model_active [NOUT];
  int   pend [NOUT];
  logic model_sh [L];
  logic model_tail;

  always #5 prog_clk = ~prog_clk;

  sb_param_cfg_tile dut (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_head(ccff_head), .cfg_en(cfg_en),
    .cfg_commit(cfg_commit), .cfg_abort(cfg_abort), .ccff_tail(ccff_tail),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .chanx_right_in(chan_v[0]), .chany_top_in(chan_v[1]),
    .chany_bottom_in(chan_v[2]), .chanx_left_in(chan_v[3]),
    .pin_right_in(pin_v[0]), .pin_top_in(pin_v[1]),
    .pin_bottom_in(pin_v[2]), .pin_left_in(pin_v[3]),
    .chanx_right_out(co_r), .chany_top_out(co_t),
    .chany_bottom_out(co_b), .chanx_left_out(co_l)
  );

  typedef struct {
    int   side; int trk; int sel;
    int   kind; int sside; int sidx;
    logic exp;
  } vec_t;
  vec_t vecs [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge prog_clk);
    #1;
  endtask

  // Output expected from the committed selections and the current inputs.
  function automatic logic [NOUT-1:0] exp_outs();
    logic [NOUT-1:0] r;
    int v, idx, grp, n;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < CHAN_W; t++) begin
        v = model_active[s*CHAN_W + t];
        if (v >= 1 && v <= NUM_PIN) r[s*CHAN_W + t] = pin_v[s][v-1];
        else if (v > NUM_PIN && v <= N_IN) begin
          idx = v - NUM_PIN - 1;
          grp = idx / CHAN_W;
          n = 0;
          for (int q = 0; q < 4; q++) begin
            if (q != s) begin
              if (n == grp) r[s*CHAN_W + t] = chan_v[q][idx % CHAN_W];
              n++;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [L-1:0] make_cfg(input logic odd);
    logic [L-1:0] v;
    v = '0;
    for (int k = 0; k < NOUT; k++) v[k*SEL_W +: SEL_W] = SEL_W'(pend[k]);
`ifdef SB_CFG_PARITY_EN
    v[CFG_BITS] = (^v[CFG_BITS-1:0]) ^ odd;
`else
    if (odd) v[0] = v[0];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) model_sh[i] = 1'b0;
    model_tail = 1'b0;
    for (int k = 0; k < NOUT; k++) model_active[k] = 0;
  endtask

  task automatic shift_one(input logic b);
    ccff_head = b;
    cfg_en = 1'b1;
    cyc();
    cfg_en = 1'b0;
    model_tail = model_sh[L-1];
    for (int i = L-1; i > 0; i--) model_sh[i] = model_sh[i-1];
    model_sh[0] = b;
    check("tail", ccff_tail, model_tail);
  endtask

  task automatic load(input logic [L-1:0] v, input int n);
    for (int i = n-1; i >= 0; i--) shift_one(v[i]);
  endtask

  task automatic take_commit();
    int v;
    for (int k = 0; k < NOUT; k++) begin
      v = 0;
      for (int b = 0; b < SEL_W; b++) if (model_sh[k*SEL_W + b]) v += (1 << b);
      model_active[k] = v;
    end
  endtask

  task automatic do_commit(input string nm, input logic exp_ack);
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    check({nm, "_ack"}, cfg_ack, exp_ack);
    if (exp_ack) take_commit();
    cyc();
    check({nm, "_ack_drop"}, cfg_ack, 1'b0);
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 4; s++) begin chan_v[s] = '0; pin_v[s] = '0; end
  endtask

  task automatic do_abort();
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 0,  1, K_PIN,  0, 0, 1'b1};
    vecs[1]  = '{0, 0, 19, K_CHAN, 3, 4, 1'b1};
    vecs[2]  = '{0, 0, 25, K_ALL,  0, 0, 1'b0};
    vecs[3]  = '{1, 2,  5, K_CHAN, 0, 0, 1'b1};
    vecs[4]  = '{1, 2, 10, K_CHAN, 2, 0, 1'b1};
    vecs[5]  = '{3, 4, 19, K_CHAN, 2, 4, 1'b1};
    vecs[6]  = '{3, 4,  4, K_PIN,  3, 3, 1'b1};
    vecs[7]  = '{2, 1,  7, K_CHAN, 0, 2, 1'b1};
    vecs[8]  = '{2, 1,  7, K_CHAN, 0, 1, 1'b0};
    vecs[9]  = '{0, 3,  0, K_ALL,  0, 0, 1'b0};
    vecs[10] = '{0, 3, 20, K_ALL,  0, 0, 1'b0};
    vecs[11] = '{3, 0, 15, K_SELF, 0, 0, 1'b0};
    vecs[12] = '{3, 0, 15, K_CHAN, 2, 0, 1'b1};
    vecs[13] = '{2, 4,  4, K_PIN,  2, 3, 1'b1};

    ccff_head = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0; cfg_abort = 1'b0;
    for (int s = 0; s < 4; s++) begin chan_v[s] = '1; pin_v[s] = '1; end
    pReset = 1'b1;
    cyc(); cyc();
    pReset = 1'b0;
    model_reset();
    cyc();
    check("rst_outs", outs, '0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_tail", ccff_tail, 1'b0);
    check("rst_ack", cfg_ack, 1'b0);

    // Decode table: one selection under test, a single source driven.
    foreach (vecs[i]) begin
      clear_inputs();
      case (vecs[i].kind)
        K_PIN:   pin_v[vecs[i].sside][vecs[i].sidx] = 1'b1;
        K_CHAN:  chan_v[vecs[i].sside][vecs[i].sidx] = 1'b1;
        K_ALL:   for (int s = 0; s < 4; s++) begin chan_v[s] = '1; pin_v[s] = '1; end
        default: chan_v[vecs[i].side] = '1;
      endcase
      for (int k = 0; k < NOUT; k++) pend[k] = 0;
      pend[vecs[i].side*CHAN_W + vecs[i].trk] = vecs[i].sel;
      load(make_cfg(1'b0), L);
      do_commit("tbl", 1'b1);
      check($sformatf("tbl%0d_bit", i), outs[vecs[i].side*CHAN_W + vecs[i].trk], vecs[i].exp);
      check($sformatf("tbl%0d_all", i), outs, exp_outs());
    end

    // Random configurations and random inputs against the model.
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NOUT; k++) pend[k] = $urandom_range(0, 31);
      load(make_cfg(1'b0), L);
      do_commit("rnd", 1'b1);
      for (int p = 0; p < 4; p++) begin
        for (int s = 0; s < 4; s++) begin
          chan_v[s] = CHAN_W'($urandom);
          pin_v[s]  = NUM_PIN'($urandom);
        end
        #1;
        check($sformatf("rnd%0d_%0d", it, p), outs, exp_outs());
      end
    end

    // Routing holds through a load and only switches on commit.
    clear_inputs();
    pin_v[0][0] = 1'b1;
    for (int k = 0; k < NOUT; k++) pend[k] = 0;
    pend[0] = 1;
    load(make_cfg(1'b0), L);
    do_commit("hold_a", 1'b1);
    check("hold_pin", outs[0], 1'b1);
    pend[0] = 19;
    load(make_cfg(1'b0), L/2);
    check("hold_mid", outs, exp_outs());
    do_abort();
    load(make_cfg(1'b0), L);
    check("hold_full", outs[0], 1'b1);
    do_commit("hold_b", 1'b1);
    check("left4_lo", outs[0], 1'b0);
    chan_v[3][4] = 1'b1;
    #1;
    check("left4_hi", outs[0], 1'b1);

    // Short load then commit: error, routing kept; abort clears; full reload accepted.
    pin_v[0] = '1;
    for (int k = 0; k < NOUT; k++) pend[k] = $urandom_range(0, 19);
    load(make_cfg(1'b0), 60);
    do_commit("short", 1'b0);
    check("short_err", cfg_err, 1'b1);
    check("short_outs", outs, exp_outs());
    do_abort();
    check("abort_err", cfg_err, 1'b0);
    load(make_cfg(1'b0), L);
    do_commit("reload", 1'b1);
    check("reload_err", cfg_err, 1'b0);
    check("reload_outs", outs, exp_outs());

    // Overshift goes to error; commit there is ignored.
    load(make_cfg(1'b0), L);
    shift_one(1'b1);
    check("over_err", cfg_err, 1'b1);
    do_commit("over", 1'b0);
    check("over_outs", outs, exp_outs());
    do_abort();

    // en+commit on a full chain: commit accepted, the shift is suppressed.
    for (int k = 0; k < NOUT; k++) pend[k] = $urandom_range(0, 19);
    load(make_cfg(1'b0), L);
    ccff_head = ~model_sh[L-1];
    cfg_en = 1'b1; cfg_commit = 1'b1;
    cyc();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    check("encm_ack", cfg_ack, 1'b1);
    check("encm_tail", ccff_tail, model_tail);
    check("encm_err", cfg_err, 1'b0);
    take_commit();
    check("encm_outs", outs, exp_outs());
    cyc();
    check("encm_ack_drop", cfg_ack, 1'b0);

`ifdef SB_CFG_PARITY_EN
    for (int k = 0; k < NOUT; k++) pend[k] = $urandom_range(0, 19);
    load(make_cfg(1'b1), L);
    do_commit("par_odd", 1'b0);
    check("par_odd_err", cfg_err, 1'b1);
    check("par_odd_outs", outs, exp_outs());
    do_abort();
    load(make_cfg(1'b0), L);
    do_commit("par_even", 1'b1);
    check("par_even_outs", outs, exp_outs());
`endif

    // Reset in the middle of a load clears the committed routing.
    for (int s = 0; s < 4; s++) begin chan_v[s] = '1; pin_v[s] = '1; end
    for (int k = 0; k < NOUT; k++) pend[k] = 1;
    load(make_cfg(1'b0), L);
    do_commit("pre_rst", 1'b1);
    check("pre_rst_outs", outs, {NOUT{1'b1}});
    load(make_cfg(1'b0), 30);
    pReset = 1'b1;
    cyc();
    pReset = 1'b0;
    model_reset();
    check("midrst_outs", outs, '0);
    check("midrst_err", cfg_err, 1'b0);
    check("midrst_tail", ccff_tail, 1'b0);
    check("midrst_ack", cfg_ack, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
